prng_sched: RTL and testbench
=============================

# prng_sched

Shared-resource controller for the 32-bit Fibonacci PRNG. It owns one LFSR core and handles seeding, warm-up and refill sequencing. It grants 32-bit random words to up to NUM_REQ requesters using round-robin arbitration. It sits between the LFSR datapath and the consumer blocks, for example the per-channel randomisers, so that each consumer gets a non-overlapping word instead of a shifted copy of another consumer's word.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WARMUP_CYCLES, 64, LFSR shifts discarded after any seed load (>=1)
- STEPS_PER_WORD, 32, LFSR shifts between successive granted words (1..32)
- DEFAULT_SEED, 32'h0000_0001, seed used at reset and in place of an all-zero seed

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- seed_valid  in  1  new seed offered
- seed  in  32  seed value
- seed_ready  out  1  seed accepted when seed_valid & seed_ready
- req  in  NUM_REQ  per-requester word request, level, held until gnt
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rnd_valid  out  1  rnd_data valid; equals |gnt
- rnd_data  out  32  granted random word
- busy  out  1  high in WARMUP or REFILL

## Operation
- LFSR bit order is [31:0]. One shift is: next = {tap, q[31:1]}, where tap = q[0]^q[10]^q[30]^q[31]. The core shifts only when shift_en is high, one bit per cycle.
- FSM states: WARMUP, READY, REFILL.
- Reset:
  - LFSR is set to DEFAULT_SEED, the shift counter to 0 and the RR pointer to 0.
  - State goes to WARMUP.
  - All outputs are 0 except busy=1.
- WARMUP:
  - shift_en=1 and the counter counts WARMUP_CYCLES shifts.
  - On the last shift, go to READY.
- READY:
  - seed_ready=1 and busy=0.
  - Priority 1, seed_valid=1: load the seed (DEFAULT_SEED if seed==0), clear the counter and go to WARMUP. Any pending requests stay pending.
  - Priority 2, any req bit set: pick the first set bit at or after the RR pointer, with wrap-around. Next cycle, pulse gnt for that bit, set rnd_valid=1 and drive rnd_data with the LFSR value sampled at the decision edge. Set the pointer to the granted index+1 mod NUM_REQ. Go to REFILL.
  - Otherwise hold; the LFSR does not shift.
- REFILL:
  - shift_en=1 for STEPS_PER_WORD cycles, then go to READY.
  - Requests and seeds are ignored, with seed_ready=0.
- A requester may drop req before it is granted, and this causes no error. gnt is never given to a requester whose req was low at the decision edge.
- rnd_data holds its last granted value between grants. It resets to 0.

## Timing
- Grant latency is 1 cycle: req sampled high in READY at edge k gives gnt high for the cycle after edge k.
- The REFILL shifts begin on the same edge that raises gnt.
- Throughput is 1 word per STEPS_PER_WORD+1 cycles.
- After a seed is accepted, the first grant is possible at the earliest WARMUP_CYCLES+1 cycles later.
- If seed_valid and req are both high in READY, the seed wins and no gnt is issued that cycle.
- When reset is asserted mid-REFILL or mid-WARMUP:
  - gnt and rnd_valid go low immediately.
  - The full reset state is restored, and the in-flight grant is not repeated.
- The all-ones LFSR state is legal and is never forced. Only all-zero is replaced.

## Configuration
- PRNG_SCHED_STATS_EN defined:
  - Adds a 16-bit saturating grant counter per requester, stopping at 16'hFFFF.
  - Adds the output port gnt_count (NUM_REQ*16 bits, requester 0 in the LSBs).
  - Counters clear on reset and on seed load.
- PRNG_SCHED_STATS_EN undefined: no counters and no gnt_count port. Core behaviour is identical.

## Structure
- Package prng_pkg holds:
  - the tap index constants (0, 10, 30, 31)
  - PRNG_W=32
  - the default seed constant
  - the FSM state enum {WARMUP, READY, REFILL}
- Sub-module prng_lfsr_core has clk, reset, load, load_val[31:0], shift_en and q[31:0].
  - It holds no arbitration logic.
  - load has priority over shift_en.
- The RR arbiter and FSM live in prng_sched.

## Test plan
- Reset check, with WARMUP_CYCLES=4 and DEFAULT_SEED=1: after reset is released, busy=1 for 4 cycles, then READY with seed_ready=1.
- LFSR sequence check: LFSR values on successive shifts from 1 are 32'h8000_0000, then 32'hC000_0000, then 32'h6000_0000.
- Single-requester grant, with STEPS_PER_WORD=32: hold req=4'b0001 in READY.
  - gnt=0001 appears 1 cycle later with rnd_data equal to the LFSR value sampled at the decision edge.
  - The next gnt comes exactly 33 cycles after the first.
  - The two words differ.
- Round-robin fairness: hold req=4'b1111 for 8 grants; the gnt sequence is 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
- Seed versus request and zero seed: with seed_valid=1, seed=0 and req=0001 in the same READY cycle:
  - No gnt is issued, the LFSR reloads to 32'h0000_0001 and WARMUP restarts.
  - req is granted after warm-up.
- Reset mid-REFILL: assert reset 5 cycles into REFILL; gnt=0, rnd_valid=0 and rnd_data=0 immediately, and the pointer is 0. With PRNG_SCHED_STATS_EN defined, gnt_count is 0.

Source files
------------

// File: rtl/prng_sched_pkg.sv
// ==== prng_pkg : shared constants, state encoding and LFSR step for prng_sched (rev 1.0) ====
`default_nettype none

package prng_pkg;

  localparam int PRNG_W = 32;

  localparam int TAP_A = 0;
  localparam int TAP_B = 10;
  localparam int TAP_C = 30;
  localparam int TAP_D = 31;

  localparam logic [PRNG_W-1:0] DEFAULT_SEED_C = 32'h0000_0001;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    READY  = 2'd1,
    REFILL = 2'd2
  } prng_state_t;

  // Fibonacci step: feedback enters at the MSB, the register moves toward bit 0.
  function automatic logic [PRNG_W-1:0] lfsr_shift(input logic [PRNG_W-1:0] q);
    return {q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D], q[PRNG_W-1:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prng_sched_if.sv
// ==== prng_sched_if : seed / request / grant bundle between prng_sched and its consumers (rev 1.0) ====
`default_nettype none

interface prng_sched_if #(
  parameter int NUM_REQ = 4
);

  logic                          seed_valid;
  logic [prng_pkg::PRNG_W-1:0]   seed;
  logic                          seed_ready;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            gnt;
  logic                          rnd_valid;
  logic [prng_pkg::PRNG_W-1:0]   rnd_data;
  logic                          busy;

  modport master (
    output seed_valid, seed, req,
    input  seed_ready, gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  seed_valid, seed, req,
    output seed_ready, gnt, rnd_valid, rnd_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/prng_sched_lfsr_core.sv
// ==== prng_lfsr_core : 32-bit Fibonacci LFSR register, load has priority over shift (rev 1.0) ====
`default_nettype none

module prng_lfsr_core
  import prng_pkg::*;
#(
  parameter logic [PRNG_W-1:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift_en,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= DEFAULT_SEED;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= lfsr_shift(q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/prng_sched.sv
// ==== prng_sched : round-robin word scheduler over a shared 32-bit LFSR (rev 1.0) ====
// Optional PRNG_SCHED_STATS_EN adds per-requester 16-bit saturating grant counters on gnt_count.
`default_nettype none

module prng_sched
  import prng_pkg::*;
#(
  parameter int                NUM_REQ        = 4,
  parameter int                WARMUP_CYCLES  = 64,
  parameter int                STEPS_PER_WORD = 32,
  parameter logic [PRNG_W-1:0] DEFAULT_SEED   = DEFAULT_SEED_C
) (
  input  logic        clk,
  input  logic        reset,
  prng_sched_if.slave bus
`ifdef PRNG_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] gnt_count
`endif
);

  localparam int CNT_MAX = (WARMUP_CYCLES > STEPS_PER_WORD) ? WARMUP_CYCLES : STEPS_PER_WORD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFILL_LAST = CNT_W'(STEPS_PER_WORD - 1);

  prng_state_t        r_state;
  prng_state_t        w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_pick;
  logic               w_found;
  logic               w_shift_en;
  logic               w_load;
  logic               w_grant;
  logic               w_cnt_clr;
  logic               w_seed_ready;
  logic               w_busy;
  logic [NUM_REQ-1:0] r_gnt;
  logic [PRNG_W-1:0]  r_rnd_data;
  logic [PRNG_W-1:0]  w_q;
  logic [PRNG_W-1:0]  w_load_val;

  // Index arithmetic modulo NUM_REQ, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  assign w_load_val = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;

  prng_lfsr_core #(
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .shift_en (w_shift_en),
    .q        (w_q)
  );

  // First requesting index at or after the pointer, wrapping once around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req[wrap_add(r_ptr, i)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_ptr, i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WARMUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
    w_grant      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_seed_ready = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      WARMUP: begin
        w_shift_en = 1'b1;
        if (r_cnt == WARM_LAST) begin
          w_state_next = READY;
          w_cnt_clr    = 1'b1;
        end
      end
      READY: begin
        w_busy       = 1'b0;
        w_seed_ready = 1'b1;
        if (bus.seed_valid) begin
          w_load       = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = WARMUP;
        end else if (w_found) begin
          w_grant      = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = REFILL;
        end
      end
      REFILL: begin
        w_shift_en = 1'b1;
        if (r_cnt == REFILL_LAST) begin
          w_state_next = READY;
          w_cnt_clr    = 1'b1;
        end
      end
      default: begin
        w_state_next = WARMUP;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_rnd_data <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // The word handed out is the pre-refill value; the shift starts next cycle.
      r_gnt <= w_grant ? (NUM_REQ'(1) << w_pick) : '0;
      if (w_grant) begin
        r_rnd_data <= w_q;
        r_ptr      <= wrap_add(w_pick, 1);
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.rnd_valid  = |r_gnt;
  assign bus.rnd_data   = r_rnd_data;
  assign bus.seed_ready = w_seed_ready;
  assign bus.busy       = w_busy;

`ifdef PRNG_SCHED_STATS_EN
  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
      logic [15:0] r_count;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_count <= '0;
        end else if (w_load) begin
          r_count <= '0;
        end else if (w_grant && (w_pick == PTR_W'(g)) && (r_count != 16'hFFFF)) begin
          r_count <= r_count + 16'd1;
        end
      end
      assign gnt_count[g*16 +: 16] = r_count;
    end
  endgenerate
`endif

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(r_gnt));

endmodule

`default_nettype wire

// File: tb/tb_prng_sched.sv
// ==== tb_prng_sched : randomized self-checking bench for prng_sched against a word-index model (rev 1.0) ====
`default_nettype none

module tb_prng_sched;

  localparam int          NUM_REQ = 4;
  localparam int          WARMUP  = 4;
  localparam int          STEPS   = 32;
  localparam logic [31:0] DSEED   = 32'h0000_0001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prng_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef PRNG_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] gnt_count;
`endif

  prng_sched #(
    .NUM_REQ        (NUM_REQ),
    .WARMUP_CYCLES  (WARMUP),
    .STEPS_PER_WORD (STEPS),
    .DEFAULT_SEED   (DSEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef PRNG_SCHED_STATS_EN
    ,
    .gnt_count (gnt_count)
`endif
  );

  logic        c_load;
  logic        c_shift;
  logic [31:0] c_val;
  logic [31:0] c_q;

  prng_lfsr_core #(.DEFAULT_SEED(DSEED)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (c_load),
    .load_val (c_val),
    .shift_en (c_shift),
    .q        (c_q)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_seed;
  int          m_words;
  int          m_ptr;
  logic [31:0] m_last;
  int          m_cnt[NUM_REQ];

  // Word j after a seed is the seed advanced by WARMUP + j*STEPS shifts.
  function automatic logic [31:0] adv(input logic [31:0] q, input int n);
    logic [31:0] v;
    v = q;
    for (int i = 0; i < n; i++) v = {v[0] ^ v[10] ^ v[30] ^ v[31], v[31:1]};
    return v;
  endfunction

  function automatic logic [31:0] word_at(input int j);
    return adv(m_seed, WARMUP + j * STEPS);
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_seed = DSEED; m_words = 0; m_ptr = 0; m_last = '0;
    for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = 0;
  endtask

  task automatic model_seed(input logic [31:0] s);
    m_seed = (s == '0) ? DSEED : s; m_words = 0;
    for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = 0;
  endtask

  task automatic model_grant(input int idx);
    m_last = word_at(m_words); m_words++; m_ptr = (idx + 1) % NUM_REQ;
    if (m_cnt[idx] < 65535) m_cnt[idx]++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.seed_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (bus.seed_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready: seed_ready=%b after %0d cycles, want 1", bus.seed_ready, n);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rnd_valid && n < 100);
    checks++;
    if (bus.rnd_valid !== 1'b1) begin
      errors++; $display("FAIL wait_gnt: no grant within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.seed_valid = 1'b0; bus.seed = '0;
    c_load = 1'b0; c_shift = 1'b0; c_val = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
    checks++; if (bus.rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_rnd_valid: got %b want 0", bus.rnd_valid); end
    checks++; if (bus.rnd_data !== '0) begin errors++; $display("FAIL reset_rnd_data: got %h want 0", bus.rnd_data); end
    checks++; if (bus.seed_ready !== 1'b0) begin errors++; $display("FAIL reset_seed_ready: got %b want 0", bus.seed_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    checks++; if (c_q !== DSEED) begin errors++; $display("FAIL reset_core_q: got %h want %h", c_q, DSEED); end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < WARMUP; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.seed_ready !== 1'b0) begin
        errors++; $display("FAIL warmup_busy[%0d]: busy=%b seed_ready=%b want 1/0", i, bus.busy, bus.seed_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.seed_ready !== 1'b1) begin
      errors++; $display("FAIL warmup_done: busy=%b seed_ready=%b want 0/1", bus.busy, bus.seed_ready);
    end
  endtask

  task automatic test_lfsr_seq();
    logic [31:0] exp_seq [3];
    logic [31:0] v;
    exp_seq[0] = 32'h8000_0000; exp_seq[1] = 32'hC000_0000; exp_seq[2] = 32'h6000_0000;
    c_shift = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (c_q !== exp_seq[i]) begin errors++; $display("FAIL lfsr_seq[%0d]: got %h want %h", i, c_q, exp_seq[i]); end
    end
    v = $urandom;
    c_load = 1'b1; c_val = v;
    @(negedge clk);
    checks++; if (c_q !== v) begin errors++; $display("FAIL lfsr_load_prio: got %h want %h", c_q, v); end
    c_load = 1'b0;
    @(negedge clk);
    checks++;
    if (c_q !== adv(v, 1)) begin errors++; $display("FAIL lfsr_shift_rand: got %h want %h", c_q, adv(v, 1)); end
    c_shift = 1'b0;
  endtask

  task automatic test_round_robin();
    int n, idx;
    wait_ready();
    bus.req = '1;
    for (int g = 0; g < 8; g++) begin
      wait_gnt(n);
      idx = rr_pick(bus.req, m_ptr);
      checks++;
      if (bus.gnt !== (NUM_REQ'(1) << idx)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want idx %0d", g, bus.gnt, idx); end
      checks++;
      if (bus.rnd_data !== word_at(m_words)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", g, bus.rnd_data, word_at(m_words)); end
      checks++;
      if (n !== ((g == 0) ? 1 : STEPS + 1)) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", g, n, (g == 0) ? 1 : STEPS + 1); end
      model_grant(idx);
    end
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.rnd_valid !== 1'b0 || bus.rnd_data !== m_last) begin
      errors++; $display("FAIL rr_hold: rnd_valid=%b rnd_data=%h want 0/%h", bus.rnd_valid, bus.rnd_data, m_last);
    end
  endtask

  task automatic test_single();
    int n1, n2;
    logic [31:0] first;
    wait_ready();
    bus.req = NUM_REQ'(1);
    wait_gnt(n1);
    checks++; if (n1 !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", n1); end
    checks++; if (bus.gnt !== NUM_REQ'(1)) begin errors++; $display("FAIL single_gnt1: got %b want 0001", bus.gnt); end
    checks++; if (bus.rnd_data !== word_at(m_words)) begin errors++; $display("FAIL single_data1: got %h want %h", bus.rnd_data, word_at(m_words)); end
    first = bus.rnd_data;
    model_grant(0);
    @(negedge clk);
    checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL single_pulse: got %b want 0", bus.gnt); end
    wait_gnt(n2);
    checks++; if (n2 + 1 !== STEPS + 1) begin errors++; $display("FAIL single_gap: got %0d want %0d", n2 + 1, STEPS + 1); end
    checks++; if (bus.rnd_data !== word_at(m_words)) begin errors++; $display("FAIL single_data2: got %h want %h", bus.rnd_data, word_at(m_words)); end
    checks++; if (bus.rnd_data === first) begin errors++; $display("FAIL single_distinct: got %h twice, want different words", first); end
    model_grant(0);
    bus.req = '0;
  endtask

  task automatic test_seed_vs_req();
    int n;
    wait_ready();
    bus.seed_valid = 1'b1; bus.seed = '0; bus.req = NUM_REQ'(1);
    @(negedge clk);
    checks++;
    if (bus.rnd_valid !== 1'b0 || bus.gnt !== '0) begin errors++; $display("FAIL seed_wins: gnt=%b want 0", bus.gnt); end
    checks++;
    if (bus.busy !== 1'b1 || bus.seed_ready !== 1'b0) begin
      errors++; $display("FAIL seed_warmup: busy=%b seed_ready=%b want 1/0", bus.busy, bus.seed_ready);
    end
    checks++; if (bus.rnd_data !== m_last) begin errors++; $display("FAIL seed_hold_data: got %h want %h", bus.rnd_data, m_last); end
    bus.seed_valid = 1'b0;
    model_seed('0);
    wait_gnt(n);
    checks++; if (n !== WARMUP + 1) begin errors++; $display("FAIL seed_first_grant: got %0d want %0d", n, WARMUP + 1); end
    checks++; if (bus.gnt !== NUM_REQ'(1)) begin errors++; $display("FAIL seed_gnt: got %b want 0001", bus.gnt); end
    checks++; if (bus.rnd_data !== word_at(0)) begin errors++; $display("FAIL seed_zero_data: got %h want %h", bus.rnd_data, word_at(0)); end
    model_grant(0);
    bus.req = '0;
`ifdef PRNG_SCHED_STATS_EN
    checks++; if (gnt_count !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL seed_stats: got %h want 1 on req0", gnt_count); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    int n;
    wait_ready();
    bus.req = NUM_REQ'(2);
    wait_gnt(n);
    // Reset during the grant pulse itself must drop it asynchronously.
    reset = 1'b1; bus.req = '0;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_in_gnt: gnt=%b rnd_valid=%b want 0/0", bus.gnt, bus.rnd_valid);
    end
    reset = 1'b0; model_reset();
    wait_ready();
    bus.req = NUM_REQ'(4);
    wait_gnt(n);
    model_grant(2);
    bus.req = '0;
    repeat (4) @(negedge clk);
`ifdef PRNG_SCHED_STATS_EN
    checks++; if (gnt_count[32 +: 16] !== 16'd1) begin errors++; $display("FAIL pre_reset_stats: got %h want 1", gnt_count[32 +: 16]); end
`endif
    reset = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== '0) begin
      errors++; $display("FAIL reset_refill: gnt=%b rnd_valid=%b rnd_data=%h want 0/0/0", bus.gnt, bus.rnd_valid, bus.rnd_data);
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_refill_busy: got %b want 1", bus.busy); end
`ifdef PRNG_SCHED_STATS_EN
    checks++; if (gnt_count !== '0) begin errors++; $display("FAIL reset_stats: got %h want 0", gnt_count); end
`endif
    @(negedge clk);
    reset = 1'b0; model_reset();
    wait_ready();
    bus.req = '1;
    wait_gnt(n);
    checks++; if (bus.gnt !== NUM_REQ'(1)) begin errors++; $display("FAIL reset_ptr: got %b want 0001", bus.gnt); end
    checks++; if (bus.rnd_data !== word_at(0)) begin errors++; $display("FAIL reset_word: got %h want %h", bus.rnd_data, word_at(0)); end
    model_grant(0);
    bus.req = '0;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] r;
    logic               sv;
    logic [31:0]        s;
    int                 n, idx;
    for (int it = 0; it < 40; it++) begin
      n = 0;
      while (!bus.seed_ready && n < 200) begin
        bus.req = NUM_REQ'($urandom); bus.seed_valid = 1'($urandom); bus.seed = $urandom;
        @(negedge clk); n++;
        checks++;
        if (bus.rnd_valid !== 1'b0) begin errors++; $display("FAIL rand_busy_gnt[%0d]: gnt=%b while busy", it, bus.gnt); end
      end
      checks++;
      if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d]: never ready", it); end
      r  = NUM_REQ'($urandom);
      sv = ($urandom_range(0, 5) == 0);
      s  = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      bus.req = r; bus.seed_valid = sv; bus.seed = s;
      @(negedge clk);
      if (sv) begin
        checks++;
        if (bus.rnd_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL rand_seed[%0d]: rnd_valid=%b busy=%b want 0/1", it, bus.rnd_valid, bus.busy);
        end
        model_seed(s);
      end else if (r != '0) begin
        idx = rr_pick(r, m_ptr);
        checks++;
        if (bus.gnt !== (NUM_REQ'(1) << idx)) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want idx %0d (req %b)", it, bus.gnt, idx, r); end
        checks++;
        if (bus.rnd_data !== word_at(m_words)) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", it, bus.rnd_data, word_at(m_words)); end
        model_grant(idx);
      end else begin
        checks++;
        if (bus.rnd_valid !== 1'b0 || bus.seed_ready !== 1'b1) begin
          errors++; $display("FAIL rand_idle[%0d]: rnd_valid=%b seed_ready=%b want 0/1", it, bus.rnd_valid, bus.seed_ready);
        end
      end
      checks++;
      if (bus.rnd_data !== m_last) begin errors++; $display("FAIL rand_hold[%0d]: got %h want %h", it, bus.rnd_data, m_last); end
`ifdef PRNG_SCHED_STATS_EN
      for (int k = 0; k < NUM_REQ; k++) begin
        checks++;
        if (gnt_count[k*16 +: 16] !== 16'(m_cnt[k])) begin
          errors++; $display("FAIL rand_stats[%0d][%0d]: got %0d want %0d", it, k, gnt_count[k*16 +: 16], m_cnt[k]);
        end
      end
`endif
      bus.req = '0; bus.seed_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_round_robin();
    test_single();
    test_seed_vs_req();
    test_reset_mid_refill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
